serializer_tx: RTL and testbench
================================

SERIALIZER_TX -- requirements
Module: serializer_tx

Interface
REQ-001 Parameter FRAME_BYTES, default 3: payload bytes per frame (1..8).
REQ-002 Parameter GAP_BITS, default 2: idle-low bits appended after each frame (1..15).
REQ-003 t_clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 din  input  8  parallel byte to transmit.
REQ-006 din_valid  input  1  din is valid this cycle.
REQ-007 din_ready  output  1  holding register is empty; a byte is accepted on any edge where din_valid && din_ready.
REQ-008 sdata  output  1  registered serial line to the downstream deserializer.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 frame_done  output  1  one-cycle pulse on the edge that enters GAP.
REQ-011 underrun  output  1  one-cycle pulse when a payload byte is padded with 0x00.

Function
REQ-012 Frame format on sdata: sync 1,0,1,0; then FRAME_BYTES bytes, each MSB first; then GAP_BITS zeros.
REQ-013 States SHALL be IDLE, SYNC, DATA, GAP; sdata is 0 in IDLE and GAP.
REQ-014 Storage SHALL be one 8-bit holding register (hold, hold_full) plus one 8-bit shift register; din_ready = !hold_full.
REQ-015 IDLE->SYNC on the edge where hold_full is 1; that edge drives sdata=1 (sync bit 0).
REQ-016 SYNC lasts 4 cycles (sdata 1,0,1,0); on the edge driving sync bit 3, the shift register loads hold and hold_full clears.
REQ-017 SYNC->DATA after sync bit 3; each DATA edge drives the next shift-register bit, starting at bit 7.
REQ-018 A 3-bit bit counter and a 3-bit byte counter SHALL track position; both clear on entering SYNC.
REQ-019 On the edge driving bit 0 of a byte that is not the last, the shift register loads hold; if hold_full is 0, it loads 0x00 instead and underrun pulses.
REQ-020 After bit 0 of byte FRAME_BYTES-1: DATA->GAP, frame_done pulses.
REQ-021 GAP lasts GAP_BITS cycles, then GAP->IDLE; a new frame needs hold_full in IDLE, so the minimum inter-frame gap is GAP_BITS+1 zeros.
REQ-022 A simultaneous accept and hold-to-shift transfer on the same edge SHALL leave hold_full=1 with the new byte; no byte is lost or duplicated.
REQ-023 A byte accepted during GAP or IDLE waits in hold and starts the next frame.
REQ-024 Latency: a byte accepted at edge k (state IDLE) gives sync bit 0 at edge k+1 and its MSB at edge k+5.
REQ-025 din is ignored while din_ready is 0; din_valid need not stay high after acceptance.

Reset
REQ-026 While rst=1, independent of t_clk: state=IDLE, counters=0, hold_full=0, shift=0, sdata=0, busy=0, frame_done=0, underrun=0; din_ready=1.
REQ-027 Reset mid-frame SHALL abort the frame immediately: sdata=0, and any held byte is discarded.
REQ-028 The first edge after rst falls SHALL behave as IDLE.

Verification
REQ-029 FRAME_BYTES=3, GAP_BITS=2; bytes A5, 3C, FF offered back-to-back -> sdata 1010 10100101 00111100 11111111 00; frame_done on the GAP-entry edge; no underrun.
REQ-030 Only 0x81 offered -> sdata 1010 10000001 00000000 00000000 00; underrun pulses twice.
REQ-031 din_valid held high with 6 bytes queued -> two frames separated by exactly 3 zeros; din_ready low only while hold_full=1.
REQ-032 Accept on the same edge as a hold-to-shift transfer (REQ-022) -> next byte is transmitted once, in order.
REQ-033 rst asserted during byte 2, bit 4 -> sdata, busy, and the pulses drop to 0 asynchronously and din_ready goes to 1; after release, 0x5A gives a clean 1010 01011010 frame.
REQ-034 Loopback into the team deserializer with random payloads -> the recovered bytes match the transmitted bytes in order.

Source files
------------

// File: rtl/serializer_tx.sv
// Byte-to-serial frame transmitter: sync 1010, FRAME_BYTES payload bytes MSB first,
// then GAP_BITS idle-low bits. One holding register feeds one shift register.
module serializer_tx #(
  parameter int FRAME_BYTES = 3,
  parameter int GAP_BITS    = 2
) (
  input  logic       t_clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       sdata,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} state_t;

  localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_BITS - 1);

  state_t     state, state_nxt;
  logic [7:0] hold, shift;
  logic       hold_full;
  logic [2:0] bit_cnt, byte_cnt;
  logic [3:0] gap_cnt;
  logic       data_end;
  logic       sdata_nxt, xfer, enter_gap, accept;

  // Handshake: a byte moves on every edge where din_valid && din_ready; din_ready is
  // simply "holding register empty", so it never depends on din_valid.
  assign din_ready = !hold_full;
  assign accept    = din_valid && !hold_full;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    sdata_nxt = 1'b0;
    xfer      = 1'b0;
    enter_gap = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          state_nxt = SYNC;
          sdata_nxt = 1'b1;
        end
      end
      SYNC: begin
        // Remaining sync bits 0,1,0 follow bit_cnt[0] for bit_cnt = 0,1,2.
        sdata_nxt = bit_cnt[0];
        if (bit_cnt == 3'd2) begin
          state_nxt = DATA;
          xfer      = 1'b1;
        end
      end
      DATA: begin
        if (data_end) begin
          state_nxt = GAP;
          enter_gap = 1'b1;
        end else begin
          sdata_nxt = shift[~bit_cnt];
          if (bit_cnt == 3'd7 && byte_cnt != LAST_BYTE) xfer = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge t_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold       <= 8'h00;
      hold_full  <= 1'b0;
      shift      <= 8'h00;
      bit_cnt    <= 3'd0;
      byte_cnt   <= 3'd0;
      gap_cnt    <= 4'd0;
      data_end   <= 1'b0;
      sdata      <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nxt;
      sdata      <= sdata_nxt;
      frame_done <= enter_gap;
      underrun   <= xfer && !hold_full;
      // An accept can coincide with a transfer only when hold was empty (pad case);
      // the new byte then stays in hold for the following payload slot.
      if (accept) begin
        hold      <= din;
        hold_full <= 1'b1;
      end else if (xfer) begin
        hold_full <= 1'b0;
      end
      if (xfer) shift <= hold_full ? hold : 8'h00;
      case (state)
        IDLE: begin
          bit_cnt  <= 3'd0;
          byte_cnt <= 3'd0;
          gap_cnt  <= 4'd0;
          data_end <= 1'b0;
        end
        SYNC: bit_cnt <= (bit_cnt == 3'd2) ? 3'd0 : bit_cnt + 3'd1;
        DATA: begin
          if (!data_end) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (byte_cnt == LAST_BYTE) data_end <= 1'b1;
              else                       byte_cnt <= byte_cnt + 3'd1;
            end
          end
        end
        GAP: gap_cnt <= gap_cnt + 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serializer_tx.sv
// Directed bench for serializer_tx: table of frames with hand-computed serial streams,
// plus a mid-frame reset sequence.
module tb_serializer_tx;

  logic       t_clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       sdata;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  int checks = 0;
  int errors = 0;

  serializer_tx #(.FRAME_BYTES(3), .GAP_BITS(2)) dut (
    .t_clk      (t_clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sdata      (sdata),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  // clock / reset
  initial t_clk = 1'b0;
  always #5 t_clk = ~t_clk;

  typedef struct {
    string       name;
    logic [47:0] bytes;       // byte 0 in [47:40]
    int          n;
    int          offer_from;  // earliest cycle bytes after the first are offered
    logic [60:0] exp_bits;    // left-aligned stream from the first sync bit
    int          nbits;
    int          exp_fd;
    int          exp_und;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one vector, records the stream, then scores it. abort_at >= 0 fires an
  // asynchronous reset in that cycle and scores the reset response instead.
  task automatic run_frame(input vec_t v, input int abort_at);
    logic [60:0] got;
    int start, idx, nfd, fd_pos, nund, p;
    logic busy_after;
    got = '0; start = -1; idx = 0; nfd = 0; fd_pos = -1; nund = 0; busy_after = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge t_clk);
      if (c == abort_at) begin
        check({v.name, " hold full before rst"}, 64'(din_ready), 64'd0);
        din_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check({v.name, " rst sdata"},      64'(sdata),      64'd0);
        check({v.name, " rst busy"},       64'(busy),       64'd0);
        check({v.name, " rst frame_done"}, 64'(frame_done), 64'd0);
        check({v.name, " rst underrun"},   64'(underrun),   64'd0);
        check({v.name, " rst din_ready"},  64'(din_ready),  64'd1);
        @(negedge t_clk);
        rst = 1'b0;
        return;
      end
      if (busy && start < 0) start = c;
      if (start >= 0) begin
        p = c - start;
        if (p < v.nbits) got[60 - p] = sdata;
        if (frame_done) begin
          nfd++;
          if (fd_pos < 0) fd_pos = p;
        end
        if (p == v.nbits) busy_after = busy;
      end
      if (underrun) nund++;
      // driver: offer the next byte; it is taken at the coming edge if ready now
      if (idx < v.n && (idx == 0 || c >= v.offer_from)) begin
        din       = v.bytes[47 - 8*idx -: 8];
        din_valid = 1'b1;
        if (din_ready) idx++;
      end else begin
        din_valid = 1'b0;
        din       = 8'h00;
      end
    end
    din_valid = 1'b0;
    check({v.name, " latency"},        64'(start),      64'd2);
    check({v.name, " stream"},         64'(got),        64'(v.exp_bits));
    check({v.name, " frame_done cnt"}, 64'(nfd),        64'(v.exp_fd));
    check({v.name, " frame_done pos"}, 64'(fd_pos),     64'd28);
    check({v.name, " underrun cnt"},   64'(nund),       64'(v.exp_und));
    check({v.name, " idle after"},     64'(busy_after), 64'd0);
  endtask

  initial begin
    vecs[0] = '{"a5_3c_ff", {24'hA53CFF, 24'h0}, 3, 0,
                {30'b1010_10100101_00111100_11111111_00, 31'b0}, 30, 1, 0};
    vecs[1] = '{"only_81", {8'h81, 40'h0}, 1, 0,
                {30'b1010_10000001_00000000_00000000_00, 31'b0}, 30, 1, 2};
    vecs[2] = '{"0f_f0", {16'h0FF0, 32'h0}, 2, 0,
                {30'b1010_00001111_11110000_00000000_00, 31'b0}, 30, 1, 1};
    vecs[3] = '{"01_80_7e", {24'h01807E, 24'h0}, 3, 0,
                {30'b1010_00000001_10000000_01111110_00, 31'b0}, 30, 1, 0};
    // second byte accepted on the very edge that pads byte 2 with 0x00
    vecs[4] = '{"accept_on_xfer", {16'h81C3, 32'h0}, 2, 12,
                {30'b1010_10000001_00000000_11000011_00, 31'b0}, 30, 1, 1};
    // six bytes, valid held: two frames with exactly three zeros between
    vecs[5] = '{"six_bytes", 48'h112233445566, 6, 0,
                {30'b1010_00010001_00100010_00110011_00, 1'b0,
                 30'b1010_01000100_01010101_01100110_00}, 61, 2, 0};

    rst = 1'b1; din = 8'h00; din_valid = 1'b0;
    #12;
    check("reset sdata",      64'(sdata),      64'd0);
    check("reset busy",       64'(busy),       64'd0);
    check("reset frame_done", 64'(frame_done), 64'd0);
    check("reset underrun",   64'(underrun),   64'd0);
    check("reset din_ready",  64'(din_ready),  64'd1);
    @(negedge t_clk);
    rst = 1'b0;

    foreach (vecs[i]) run_frame(vecs[i], -1);

    // abort during byte 2 (stream position 15) with 0xFF waiting in hold
    run_frame(vecs[0], 17);
    run_frame('{"after_rst_5a", {8'h5A, 40'h0}, 1, 0,
                {30'b1010_01011010_00000000_00000000_00, 31'b0}, 30, 1, 2}, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
